// File: rtl/stream_comp_invoke.sv
// rtl/stream_comp_invoke.sv - firing (invoke) block of the stream_comp window-sum actor
module stream_comp_invoke #(
  parameter int size      = 3,
  parameter int width     = 16,
  parameter int out_width = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 invoke,
  input  logic [1:0]           next_mode_in,
  input  logic [width-1:0]     data_in,
  output logic                 rd_in,
  output logic [out_width-1:0] data_out,
  output logic                 wr_out,
  output logic                 FC,
  output logic [1:0]           next_mode_out
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_ACC, S_WRITE, S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_widx;
  logic                 r_rd_d;
  logic [width-1:0]     r_win [size];
  logic [out_width-1:0] r_acc;
  logic [out_width-1:0] r_dout;
  logic                 r_rd;
  logic                 r_wr;
  logic                 r_fc;
  logic [1:0]           r_nm;
  logic                 w_last;
  logic                 w_rd_nxt;
  logic                 w_wr_nxt;
  logic                 w_fc_nxt;
  logic [1:0]           w_nm_nxt;

  assign w_last = (r_cnt == CW'(size - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (invoke) begin
          case (next_mode_in)
            2'b00:   w_next = S_READ;
            2'b01:   w_next = S_ACC;
            2'b10:   w_next = S_WRITE;
            default: w_next = S_DONE;
          endcase
        end
      end
      S_READ:    if (w_last) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_DONE;
      S_ACC:     if (w_last) w_next = S_DONE;
      S_WRITE:   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    w_rd_nxt = (w_next == S_READ);
    w_wr_nxt = (w_next == S_WRITE);
    w_fc_nxt = (w_next == S_DONE);
    w_nm_nxt = r_nm;
    if (w_fc_nxt) begin
      case (r_state)
        S_READ, S_CAPTURE: w_nm_nxt = 2'b01;
        S_ACC:             w_nm_nxt = 2'b10;
        default:           w_nm_nxt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_widx <= '0;
      r_rd_d <= 1'b0;
      r_acc  <= '0;
      r_dout <= '0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_fc   <= 1'b0;
      r_nm   <= 2'b00;
      for (int i = 0; i < size; i++) r_win[i] <= '0;
    end else begin
      r_rd   <= w_rd_nxt;
      r_wr   <= w_wr_nxt;
      r_fc   <= w_fc_nxt;
      r_nm   <= w_nm_nxt;
      r_rd_d <= r_rd;
      r_cnt  <= (r_state == S_READ || r_state == S_ACC) ? r_cnt + 1'b1 : '0;
      // FIFO head is valid one cycle after each pop strobe.
      if (r_state == S_IDLE) begin
        r_widx <= '0;
      end else if (r_rd_d) begin
        r_win[r_widx] <= data_in;
        r_widx        <= r_widx + 1'b1;
      end
      if (r_state == S_IDLE && invoke && next_mode_in == 2'b01)
        r_acc <= '0;
      else if (r_state == S_ACC)
        r_acc <= r_acc + out_width'(r_win[r_cnt]);
      if (w_wr_nxt) r_dout <= r_acc;
    end
  end

  assign rd_in         = r_rd;
  assign wr_out        = r_wr;
  assign FC            = r_fc;
  assign data_out      = r_dout;
  assign next_mode_out = r_nm;

endmodule

// File: tb/tb_stream_comp_invoke.sv
// tb/tb_stream_comp_invoke.sv - self-checking bench for stream_comp_invoke
module tb_stream_comp_invoke;
  localparam int SIZE = 3;
  localparam int W    = 16;
  localparam int OW   = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          invoke;
  logic [1:0]    next_mode_in;
  logic [W-1:0]  data_in;
  logic          rd_in;
  logic [OW-1:0] data_out;
  logic          wr_out;
  logic          FC;
  logic [1:0]    next_mode_out;

  always #5 clk = ~clk;

  stream_comp_invoke #(.size(SIZE), .width(W), .out_width(OW)) dut (
    .clk(clk), .rst(rst), .invoke(invoke), .next_mode_in(next_mode_in),
    .data_in(data_in), .rd_in(rd_in), .data_out(data_out), .wr_out(wr_out),
    .FC(FC), .next_mode_out(next_mode_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [W-1:0] fifo[$];
  bit pop_pend = 0;
  bit rand_en  = 0;
  bit chk_en   = 0;

  bit            m_busy = 0;
  int            m_mode = 0;
  int            m_k    = 0;
  logic [W-1:0]  m_win [SIZE];
  logic [W-1:0]  m_snap[SIZE];
  logic [OW-1:0] m_acc  = '0;
  logic [OW-1:0] m_dout = '0;
  logic [1:0]    m_nm   = 2'b00;
  bit            e_rd = 0, e_wr = 0, e_fc = 0;

  int            fc_cnt = 0, last_fc_cyc = -1, rd_cnt = 0, wr_cnt = 0;
  logic [OW-1:0] last_wr_data = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Cycle offset of the FC pulse for each mode.
  function automatic int flen(int m);
    case (m)
      0:       return SIZE + 2;
      1:       return SIZE + 1;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_in", {31'd0, rd_in}, {31'd0, e_rd});
      check("wr_out", {31'd0, wr_out}, {31'd0, e_wr});
      check("FC", {31'd0, FC}, {31'd0, e_fc});
      check("data_out", 32'(data_out), 32'(m_dout));
      check("next_mode_out", 32'(next_mode_out), 32'(m_nm));
    end
    pop_pend = (rd_in === 1'b1);
    if (rd_in === 1'b1) rd_cnt++;
    if (FC === 1'b1) begin fc_cnt++; last_fc_cyc = cyc; end
    if (wr_out === 1'b1) begin wr_cnt++; last_wr_data = data_out; end

    if (rst === 1'b0) begin
      chk_en = 1;
      m_busy = 0;
      m_win  = '{default: '0};
      m_acc  = '0;
      m_dout = '0;
      m_nm   = 2'b00;
    end else if (m_busy) begin
      if (m_k == flen(m_mode)) m_busy = 0;
      else m_k++;
    end else if (invoke === 1'b1) begin
      m_busy = 1;
      m_mode = int'(next_mode_in);
      m_k    = 1;
      for (int i = 0; i < SIZE; i++) m_snap[i] = (i < fifo.size()) ? fifo[i] : '0;
    end
    e_rd = m_busy && m_mode == 0 && m_k <= SIZE;
    e_wr = m_busy && m_mode == 2 && m_k == 1;
    e_fc = m_busy && m_k == flen(m_mode);
    if (e_wr) m_dout = m_acc;
    if (e_fc) begin
      case (m_mode)
        0: begin m_win = m_snap; m_nm = 2'b01; end
        1: begin
          m_acc = '0;
          for (int i = 0; i < SIZE; i++) m_acc = m_acc + OW'(m_win[i]);
          m_nm = 2'b10;
        end
        default: m_nm = 2'b00;
      endcase
    end
    cyc++;
  end

  // FIFO head: popped token after an rd_in cycle, noise otherwise.
  always @(posedge clk) begin
    #1;
    if (pop_pend && fifo.size() > 0) data_in = fifo.pop_front();
    else data_in = W'($urandom);
    if (rand_en) while (fifo.size() < 8) fifo.push_back(W'($urandom));
  end

  task automatic fire(input logic [1:0] m, input int off, input bit hold, input logic [1:0] nm);
    int t0, f0;
    @(posedge clk); #1;
    invoke = 1'b1; next_mode_in = m; t0 = cyc; f0 = fc_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!hold) invoke = 1'b0;
      if (fc_cnt != f0) break;
    end
    invoke = 1'b0;
    check("fc_seen", 32'(fc_cnt - f0), 32'd1);
    check("fc_latency", 32'(last_fc_cyc - t0), 32'(off));
    check("mode_after_fc", 32'(next_mode_out), 32'(nm));
  endtask

  task automatic full_cycle(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [OW-1:0] exp_sum);
    int w0;
    fifo.push_back(a); fifo.push_back(b); fifo.push_back(c);
    fire(2'b00, SIZE + 2, 0, 2'b01);
    fire(2'b01, SIZE + 1, 0, 2'b10);
    w0 = wr_cnt;
    fire(2'b10, 2, 0, 2'b00);
    check("wr_pulses", 32'(wr_cnt - w0), 32'd1);
    check("result", 32'(last_wr_data), 32'(exp_sum));
  endtask

  initial begin
    int r0, f0, w0;
    rst = 1'b0; invoke = 1'b1; next_mode_in = 2'b00; data_in = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_rd", {31'd0, rd_in}, 32'd0);
    check("rst_wr", {31'd0, wr_out}, 32'd0);
    check("rst_fc", {31'd0, FC}, 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_nm", 32'(next_mode_out), 32'd0);
    rst = 1'b1; invoke = 1'b0;
    repeat (2) @(posedge clk);

    full_cycle(16'd5, 16'd7, 16'd9, 18'd21);
    full_cycle(16'hFFFF, 16'hFFFF, 16'hFFFF, 18'h2FFFD);

    fifo.push_back(16'h0123); fifo.push_back(16'h4567); fifo.push_back(16'h89AB);
    r0 = rd_cnt;
    fire(2'b00, SIZE + 2, 1, 2'b01);
    check("held_invoke_rd", 32'(rd_cnt - r0), 32'd3);
    repeat (3) @(posedge clk);

    fifo.push_back(16'd10); fifo.push_back(16'd20); fifo.push_back(16'd30);
    r0 = rd_cnt; f0 = fc_cnt;
    @(posedge clk); #1; invoke = 1'b1; next_mode_in = 2'b00;
    @(posedge clk); #1; invoke = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("abort_rd", 32'(rd_cnt - r0), 32'd2);
    check("abort_fc", 32'(fc_cnt - f0), 32'd0);
    check("abort_nm", 32'(next_mode_out), 32'd0);
    check("abort_dout", 32'(data_out), 32'd0);
    fifo.delete();
    full_cycle(16'd1, 16'd2, 16'd3, 18'd6);

    r0 = rd_cnt; w0 = wr_cnt;
    fire(2'b11, 1, 0, 2'b00);
    check("mode11_rd", 32'(rd_cnt - r0), 32'd0);
    check("mode11_wr", 32'(wr_cnt - w0), 32'd0);

    rand_en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      invoke       = ($urandom_range(0, 2) == 0);
      next_mode_in = 2'($urandom_range(0, 3));
      rst          = ($urandom_range(0, 79) != 0);
    end
    @(posedge clk); #1;
    invoke = 1'b0; rst = 1'b1; rand_en = 0;
    repeat (20) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
